// File: rtl/fyra_pkg.sv
// Shared decode/execute definitions: control bundle layout and the encodings
// the decoder and the pipeline stages agree on.
package fyra_pkg;

  typedef struct packed {
    logic       regWR;
    logic       memWR;
    logic [1:0] wbCtrl;
    logic [2:0] branchCtrl;
    logic [2:0] memCtrl;
    logic       aluS1;
    logic       aluS2;
    logic       doBranch;
    logic       doJump;
    logic [3:0] aluOp;
  } ctrl_t;

  localparam logic [3:0] ALUOP_ADD     = 4'b0000;
  localparam logic [3:0] ALUOP_ILLEGAL = 4'b1001;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;
  localparam logic [1:0] WB_IMM = 2'd3;

  localparam logic [2:0] MEM_B  = 3'b000;
  localparam logic [2:0] MEM_H  = 3'b001;
  localparam logic [2:0] MEM_W  = 3'b010;
  localparam logic [2:0] MEM_BU = 3'b100;
  localparam logic [2:0] MEM_HU = 3'b101;

  function automatic logic is_illegal(input ctrl_t c);
    return c.aluOp == ALUOP_ILLEGAL;
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Valid/ready beat carrying one decoded instruction (control bundle + payload).
interface id_ex_stage_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
);
  import fyra_pkg::*;

  logic              valid;
  logic              ready;
  ctrl_t             ctrl;
  logic [XLEN-1:0]   pc;
  logic [XLEN-1:0]   rs1_data;
  logic [XLEN-1:0]   rs2_data;
  logic [XLEN-1:0]   imm;
  logic [REG_AW-1:0] rd;

  modport master (output valid, ctrl, pc, rs1_data, rs2_data, imm, rd, input ready);
  modport slave  (input valid, ctrl, pc, rs1_data, rs2_data, imm, rd, output ready);
endinterface

// File: rtl/skid_reg.sv
// Two-entry skid buffer: main entry drives the output, skid entry absorbs the one
// beat accepted while the consumer stalls, so in_ready comes straight from a flop.
module skid_reg #(
  parameter type T = logic [7:0]
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic in_valid,
  output logic in_ready,
  input  T     in_data,
  output logic out_valid,
  input  logic out_ready,
  output T     out_data
);

  logic m_valid_reg, m_valid_next;
  logic s_valid_reg, s_valid_next;
  T     m_data_reg, m_data_next;
  T     s_data_reg, s_data_next;
  logic accept;
  logic drain;

  assign in_ready  = !s_valid_reg;
  assign out_valid = m_valid_reg;
  assign out_data  = m_data_reg;

  assign accept = in_valid && !s_valid_reg && !flush;
  assign drain  = m_valid_reg && out_ready;

  always_comb begin
    m_valid_next = m_valid_reg;
    s_valid_next = s_valid_reg;
    m_data_next  = m_data_reg;
    s_data_next  = s_data_reg;
    if (flush) begin
      m_valid_next = 1'b0;
      s_valid_next = 1'b0;
    end else if (!m_valid_reg) begin
      // skid is never occupied while main is empty
      if (accept) begin
        m_valid_next = 1'b1;
        m_data_next  = in_data;
      end
    end else if (drain) begin
      if (s_valid_reg) begin
        m_data_next = s_data_reg;
        if (accept) begin
          s_data_next = in_data;
        end else begin
          s_valid_next = 1'b0;
        end
      end else if (accept) begin
        m_data_next = in_data;
      end else begin
        m_valid_next = 1'b0;
      end
    end else if (accept) begin
      s_valid_next = 1'b1;
      s_data_next  = in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid_reg <= 1'b0;
      s_valid_reg <= 1'b0;
      m_data_reg  <= '0;
      s_data_reg  <= '0;
    end else begin
      m_valid_reg <= m_valid_next;
      s_valid_reg <= s_valid_next;
      m_data_reg  <= m_data_next;
      s_data_reg  <= s_data_next;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// Decode->execute pipeline register: skid-buffered control/payload, with write
// enables masked on bubbles and malformed decodes flagged at the head.
module id_ex_stage
  import fyra_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  id_ex_stage_if.slave  in_bus,
  id_ex_stage_if.master out_bus,
  output logic          out_illegal
);

  typedef struct packed {
    ctrl_t             ctrl;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   rs1;
    logic [XLEN-1:0]   rs2;
    logic [XLEN-1:0]   imm;
    logic [REG_AW-1:0] rd;
  } id_ex_payload_t;

  id_ex_payload_t in_payload;
  id_ex_payload_t head;
  ctrl_t          gated_ctrl;
  logic           head_valid;
  logic           skid_in_ready;

  always_comb begin
    in_payload      = '0;
    in_payload.ctrl = in_bus.ctrl;
    in_payload.pc   = in_bus.pc;
    in_payload.rs1  = in_bus.rs1_data;
    in_payload.rs2  = in_bus.rs2_data;
    in_payload.imm  = in_bus.imm;
    in_payload.rd   = in_bus.rd;
  end

  skid_reg #(.T(id_ex_payload_t)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_bus.valid),
    .in_ready  (skid_in_ready),
    .in_data   (in_payload),
    .out_valid (head_valid),
    .out_ready (out_bus.ready),
    .out_data  (head)
  );

  // Only the architectural side effects are masked; a bubble must never write.
  always_comb begin
    gated_ctrl       = head.ctrl;
    gated_ctrl.regWR = head.ctrl.regWR & head_valid;
    gated_ctrl.memWR = head.ctrl.memWR & head_valid;
  end

  assign in_bus.ready      = skid_in_ready;
  assign out_bus.valid     = head_valid;
  assign out_bus.ctrl      = gated_ctrl;
  assign out_bus.pc        = head.pc;
  assign out_bus.rs1_data  = head.rs1;
  assign out_bus.rs2_data  = head.rs2;
  assign out_bus.imm       = head.imm;
  assign out_bus.rd        = head.rd;
  assign out_illegal       = head_valid & is_illegal(head.ctrl);

endmodule
